// File: rtl/sysmgr_delay_cal.sv
// sysmgr_delay_cal: sweeps the 16 read-clock phase steps of the memory PLL,
// collects a pass/fail verdict per step, then drives the centre of the
// longest contiguous passing window (lowest index wins a tie, no wrap-around).
//
// Test handshake: test_req rises on entry to TEST and stays high until a cycle
// in which test_ack=1 is sampled (test_ok is read in that same cycle). It then
// drops on the following edge. If no ack arrives within TIMEOUT_CYCLES, the
// step is recorded as failing and test_req drops. test_ack outside TEST is ignored.
module sysmgr_delay_cal #(
  parameter logic [3:0] DEFAULT_DELAY  = 4'd8,
  parameter int         SETTLE_CYCLES  = 256,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cal_start,
  output logic        cal_busy,
  output logic        cal_done,
  output logic        cal_fail,
  output logic [3:0]  delay,
  output logic        test_req,
  input  logic        test_ack,
  input  logic        test_ok,
  output logic [15:0] pass_map,
  output logic [4:0]  win_len
);

  localparam int MAX_CNT = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_TEST, S_NEXT, S_EVAL, S_APPLY, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        step_q, step_d;
  logic [3:0]        delay_q, delay_d;
  logic [15:0]       pass_map_q, pass_map_d;
  logic [4:0]        win_len_q, win_len_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              req_q, req_d;
  logic [3:0]        run_start_q, run_start_d;
  logic [4:0]        run_len_q, run_len_d;
  logic [3:0]        best_start_q, best_start_d;
  logic [4:0]        best_len_q, best_len_d;

  // Scratch values for the window scan and the centre computation
  logic [4:0]        run_len_inc;
  logic [3:0]        run_start_cur;
  logic [4:0]        half_len;

  // State and datapath registers, all returning to their idle values on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      step_q       <= '0;
      delay_q      <= DEFAULT_DELAY;
      pass_map_q   <= '0;
      win_len_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      req_q        <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      delay_q      <= delay_d;
      pass_map_q   <= pass_map_d;
      win_len_q    <= win_len_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      req_q        <= req_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  // Next-state and datapath updates for the sweep / evaluate / apply sequence
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    step_d        = step_q;
    delay_d       = delay_q;
    pass_map_d    = pass_map_q;
    win_len_d     = win_len_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    fail_d        = fail_q;
    req_d         = req_q;
    run_start_d   = run_start_q;
    run_len_d     = run_len_q;
    best_start_d  = best_start_q;
    best_len_d    = best_len_q;
    run_len_inc   = run_len_q + 5'd1;
    run_start_cur = (run_len_q == 5'd0) ? step_q : run_start_q;
    half_len      = (best_len_q - 5'd1) >> 1;

    unique case (state_q)
      S_IDLE: begin
        if (cal_start) begin
          step_d     = '0;
          delay_d    = '0;
          pass_map_d = '0;
          fail_d     = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          req_d   = 1'b1;
          state_d = S_TEST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TEST: begin
        // An ack in the timeout cycle still records its verdict
        if (test_ack) begin
          pass_map_d[step_q] = test_ok;
          req_d              = 1'b0;
          state_d            = S_NEXT;
        end else if (cnt_q == TIMEOUT_LAST) begin
          pass_map_d[step_q] = 1'b0;
          req_d              = 1'b0;
          state_d            = S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (step_q == 4'd15) begin
          step_d       = '0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          state_d      = S_EVAL;
        end else begin
          step_d  = step_q + 4'd1;
          delay_d = step_q + 4'd1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_EVAL: begin
        // step_q doubles as the scan index here; one pass_map bit per cycle
        if (pass_map_q[step_q]) begin
          run_len_d   = run_len_inc;
          run_start_d = run_start_cur;
          if (run_len_inc > best_len_q) begin
            best_len_d   = run_len_inc;
            best_start_d = run_start_cur;
          end
        end else begin
          run_len_d = '0;
        end
        if (step_q == 4'd15) begin
          state_d = S_APPLY;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      S_APPLY: begin
        if (best_len_q == 5'd0) begin
          delay_d = DEFAULT_DELAY;
          fail_d  = 1'b1;
        end else begin
          delay_d = best_start_q + half_len[3:0];
        end
        win_len_d = best_len_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cal_busy = busy_q;
  assign cal_done = done_q;
  assign cal_fail = fail_q;
  assign delay    = delay_q;
  assign test_req = req_q;
  assign pass_map = pass_map_q;
  assign win_len  = win_len_q;

endmodule

// File: tb/tb_sysmgr_delay_cal.sv
// Bench for sysmgr_delay_cal: a memory-test responder with random ack latency,
// a bus monitor, and a window-search reference model over the pass pattern.
module tb_sysmgr_delay_cal;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 24;
  localparam int LIMIT   = 3000;

  logic        clk;
  logic        rst_n;
  logic        cal_start;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_fail;
  logic [3:0]  delay;
  logic        test_req;
  logic        test_ack;
  logic        test_ok;
  logic [15:0] pass_map;
  logic [4:0]  win_len;

  int checks   = 0;
  int failures = 0;

  // Responder controls
  logic [15:0] pattern   = '0;
  bit          resp_en   = 1'b1;
  int          noack_step = -1;

  // Monitor results
  logic [3:0] req_delay_q[$];
  int         req_len_q[$];
  int         done_cnt = 0;
  int         stab_err = 0;

  sysmgr_delay_cal #(
    .DEFAULT_DELAY (4'd8),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cal_start(cal_start),
    .cal_busy (cal_busy),
    .cal_done (cal_done),
    .cal_fail (cal_fail),
    .delay    (delay),
    .test_req (test_req),
    .test_ack (test_ack),
    .test_ok  (test_ok),
    .pass_map (pass_map),
    .win_len  (win_len)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-test responder: acks each request after 0..3 cycles with the
  // verdict pattern[delay]; stays silent at noack_step
  initial begin
    int lat;
    test_ack = 1'b0;
    test_ok  = 1'b0;
    lat = -1;
    forever begin
      @(posedge clk);
      #1;
      test_ack = 1'b0;
      test_ok  = 1'b0;
      if (!test_req) begin
        lat = -1;
      end else if (resp_en && int'(delay) != noack_step) begin
        if (lat < 0) lat = $urandom_range(0, 3);
        if (lat == 0) begin
          test_ack = 1'b1;
          test_ok  = pattern[delay];
          lat = 99;
        end else if (lat != 99) begin
          lat = lat - 1;
        end
      end
    end
  end

  // Monitor: delay at each request, request lengths, delay stability, done pulses
  initial begin
    bit   prev_req;
    int   cur_len;
    logic [3:0] req_delay_now;
    prev_req = 1'b0;
    cur_len = 0;
    req_delay_now = '0;
    forever begin
      @(negedge clk);
      if (test_req && !prev_req) begin
        req_delay_q.push_back(delay);
        req_delay_now = delay;
        cur_len = 0;
      end
      if (test_req) begin
        cur_len++;
        if (delay !== req_delay_now) stab_err++;
      end
      if (!test_req && prev_req) req_len_q.push_back(cur_len);
      if (cal_done === 1'b1) done_cnt++;
      prev_req = test_req;
    end
  end

  // Reference model: longest run of ones (first found wins), centre rounded down
  function automatic void model(input logic [15:0] p, output logic [4:0] len,
                                output logic [3:0] d, output bit fail);
    int best_len, best_start;
    best_len = 0;
    best_start = 0;
    for (int s = 0; s < 16; s++) begin
      int l;
      l = 0;
      while (s + l < 16 && p[s + l]) l++;
      if (l > best_len) begin
        best_len = l;
        best_start = s;
      end
    end
    len  = 5'(best_len);
    fail = (best_len == 0);
    d    = fail ? 4'd8 : 4'(best_start + (best_len - 1) / 2);
  endfunction

  function automatic bit sweep_seq_ok();
    if (req_delay_q.size() != 16) return 1'b0;
    for (int k = 0; k < 16; k++)
      if (req_delay_q[k] !== 4'(k)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_monitor();
    req_delay_q.delete();
    req_len_q.delete();
    done_cnt = 0;
    stab_err = 0;
  endtask

  // Driver: pulse cal_start, wait (bounded) for cal_done, then a few idle cycles
  task automatic run_cal(output bit timed_out, output logic busy_after_start,
                         output logic busy_at_done);
    int n;
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    busy_after_start = cal_busy;
    n = 0;
    while (cal_done !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= LIMIT);
    busy_at_done = cal_busy;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cal_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (delay !== 4'd8 || pass_map !== 16'h0 || win_len !== 5'd0 ||
        cal_busy !== 1'b0 || cal_done !== 1'b0 || cal_fail !== 1'b0 || test_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: delay=%0d pass_map=%h win_len=%0d busy=%b done=%b fail=%b req=%b, want 8 0000 0 0 0 0 0",
               delay, pass_map, win_len, cal_busy, cal_done, cal_fail, test_req);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_patterns();
    logic [15:0] pats[6];
    logic [4:0]  exp_len;
    logic [3:0]  exp_d;
    bit          exp_fail, to;
    logic        b0, b1;
    pats = '{16'hFFFF, 16'h01F8, 16'h3C06, 16'h0707, 16'h0000, 16'h8001};
    noack_step = -1;
    for (int i = 0; i < 6; i++) begin
      pattern = pats[i];
      model(pattern, exp_len, exp_d, exp_fail);
      clear_monitor();
      run_cal(to, b0, b1);
      checks++;
      if (to || b0 !== 1'b1 || b1 !== 1'b0 || done_cnt != 1) begin
        failures++;
        $display("FAIL pat%0d_handshake: timeout=%0d busy_after_start=%b busy_at_done=%b done_pulses=%0d, want 0 1 0 1",
                 i, to, b0, b1, done_cnt);
      end
      checks++;
      if (pass_map !== pattern || win_len !== exp_len || delay !== exp_d || cal_fail !== exp_fail) begin
        failures++;
        $display("FAIL pat%0d_result: pass_map=%h win_len=%0d delay=%0d fail=%b, want %h %0d %0d %b",
                 i, pass_map, win_len, delay, cal_fail, pattern, exp_len, exp_d, exp_fail);
      end
      checks++;
      if (!sweep_seq_ok() || stab_err != 0) begin
        failures++;
        $display("FAIL pat%0d_sweep: requests=%0d delay_changes_in_test=%0d, want 16 in order 0..15 and 0",
                 i, req_delay_q.size(), stab_err);
      end
    end
  endtask

  task automatic test_timeout();
    logic [4:0] exp_len;
    logic [3:0] exp_d;
    bit         exp_fail, to;
    logic       b0, b1;
    pattern = 16'hFFFF;
    noack_step = 4;
    clear_monitor();
    run_cal(to, b0, b1);
    model(16'hFFEF, exp_len, exp_d, exp_fail);
    checks++;
    if (to || pass_map !== 16'hFFEF || win_len !== exp_len || delay !== exp_d || cal_fail !== 1'b0) begin
      failures++;
      $display("FAIL timeout_result: to=%0d pass_map=%h win_len=%0d delay=%0d fail=%b, want 0 ffef %0d %0d 0",
               to, pass_map, win_len, delay, cal_fail, exp_len, exp_d);
    end
    checks++;
    if (req_len_q.size() != 16 || req_len_q[4] != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_req_len: requests=%0d step4_req_cycles=%0d, want 16 %0d",
               req_len_q.size(), (req_len_q.size() > 4) ? req_len_q[4] : -1, TIMEOUT);
    end
    noack_step = -1;
  endtask

  task automatic test_ignored_inputs();
    int n;
    bit to;
    // step 0 fails, all others pass: a stray ack with ok=1 during SETTLE must not set bit 0
    pattern = 16'hFFFE;
    clear_monitor();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    test_ack = 1'b1;
    test_ok  = 1'b1;
    repeat (40) @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    n = 0;
    while (cal_done !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    to = (n >= LIMIT);
    repeat (4) @(negedge clk);
    checks++;
    if (to || done_cnt != 1 || !sweep_seq_ok()) begin
      failures++;
      $display("FAIL busy_start_ignored: to=%0d done_pulses=%0d requests=%0d, want 0 1 16",
               to, done_cnt, req_delay_q.size());
    end
    checks++;
    if (pass_map !== 16'hFFFE || win_len !== 5'd15 || delay !== 4'd8) begin
      failures++;
      $display("FAIL stray_ack_ignored: pass_map=%h win_len=%0d delay=%0d, want fffe 15 8",
               pass_map, win_len, delay);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    bit to;
    logic b0, b1;
    pattern = 16'hFFFF;
    noack_step = 6;
    clear_monitor();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    n = 0;
    while (!(test_req === 1'b1 && delay === 4'd6) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= LIMIT) begin
      failures++;
      $display("FAIL reach_step6: test_req=%b delay=%0d, want 1 6", test_req, delay);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (test_req !== 1'b0 || delay !== 4'd8 || cal_busy !== 1'b0 || pass_map !== 16'h0 || win_len !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid_sweep: req=%b delay=%0d busy=%b pass_map=%h win_len=%0d, want 0 8 0 0000 0",
               test_req, delay, cal_busy, pass_map, win_len);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    noack_step = -1;
    @(negedge clk);
    test_ack = 1'b1;
    test_ok  = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (test_req !== 1'b0 || cal_busy !== 1'b0 || pass_map !== 16'h0 || done_cnt != 0 || delay !== 4'd8) begin
      failures++;
      $display("FAIL late_ack_ignored: req=%b busy=%b pass_map=%h done_pulses=%0d delay=%0d, want 0 0 0000 0 8",
               test_req, cal_busy, pass_map, done_cnt, delay);
    end
    pattern = 16'h0FF0;
    clear_monitor();
    run_cal(to, b0, b1);
    checks++;
    if (to || done_cnt != 1 || !sweep_seq_ok() || pass_map !== 16'h0FF0 || win_len !== 5'd8 || delay !== 4'd7) begin
      failures++;
      $display("FAIL recal_after_reset: to=%0d done=%0d pass_map=%h win_len=%0d delay=%0d, want 0 1 0ff0 8 7",
               to, done_cnt, pass_map, win_len, delay);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_map;
    logic [4:0]  exp_len;
    logic [3:0]  exp_d;
    bit          exp_fail, to;
    logic        b0, b1;
    for (int i = 0; i < 8; i++) begin
      pattern = 16'($urandom);
      if (i % 2 == 1) pattern = pattern | 16'($urandom);
      noack_step = (i % 3 == 2) ? int'($urandom_range(0, 15)) : -1;
      exp_map = pattern;
      if (noack_step >= 0) exp_map[noack_step] = 1'b0;
      model(exp_map, exp_len, exp_d, exp_fail);
      clear_monitor();
      run_cal(to, b0, b1);
      checks++;
      if (to || done_cnt != 1 || stab_err != 0 || pass_map !== exp_map || win_len !== exp_len ||
          delay !== exp_d || cal_fail !== exp_fail) begin
        failures++;
        $display("FAIL rand%0d: to=%0d done=%0d stab=%0d pass_map=%h win_len=%0d delay=%0d fail=%b, want 0 1 0 %h %0d %0d %b",
                 i, to, done_cnt, stab_err, pass_map, win_len, delay, cal_fail,
                 exp_map, exp_len, exp_d, exp_fail);
      end
    end
    noack_step = -1;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_timeout();
    test_ignored_inputs();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
